i2c_txn_arbiter: RTL

- Round-robin arbiter and sequencer that shares one i2c_master instance among N_REQ requesters.
- Accepts single-byte read/write requests and holds the master in reset between transactions.
- Latches the winning request onto the master inputs and drives the master's ack/update strobes.
- Returns read data and completion status to the winning requester, tagged with its index.

---
 rtl/i2c_txn_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master among N_REQ single-byte requesters.
// Define I2C_ARB_TIMEOUT_EN to add a watchdog that aborts stalled transactions with rsp_err.
module i2c_txn_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ACK1_DLY = 12,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_wr,
  input  logic [7*N_REQ-1:0]       req_addr,
  input  logic [8*N_REQ-1:0]       req_din,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [7:0]               rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     m_rst,
  output logic                     m_wr,
  output logic [6:0]               m_addr,
  output logic [7:0]               m_din,
  output logic                     m_update,
  output logic                     m_send_ack_start,
  output logic                     m_send_ack_end,
  input  logic                     m_done,
  input  logic [7:0]               m_temprd
);
  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(ACK1_DLY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ACK1_DLY - 1);

  if (N_REQ < 2 || N_REQ > 8 || ACK1_DLY < 1 || TIMEOUT < 1) begin : gen_param_check
    $error("i2c_txn_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {StIdle, StLaunch, StAddrPh, StDataPh, StRecover} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]    rsp_id_q, rsp_id_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic              m_rst_q, m_rst_d;
  logic              m_wr_q, m_wr_d;
  logic [6:0]        m_addr_q, m_addr_d;
  logic [7:0]        m_din_q, m_din_d;
  logic              strobe_q, strobe_d;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
  logic [WdW-1:0] wd_q, wd_d;
`endif

  // Winner: first set bit at or above the pointer, else the lowest set bit (wrap-around).
  logic [IdW-1:0] win, win_lo, win_hi;
  logic           found_hi;
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    found_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = IdW'(i);
        if (i >= int'(ptr_q)) begin
          win_hi   = IdW'(i);
          found_hi = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  logic [N_REQ-1:0] sel_gnt;
  logic             sel_wr;
  logic [6:0]       sel_addr;
  logic [7:0]       sel_din;
  always_comb begin
    sel_gnt  = '0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IdW'(i)) begin
        sel_gnt[i] = 1'b1;
        sel_wr     = req_wr[i];
        sel_addr   = req_addr[7*i +: 7];
        sel_din    = req_din[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    m_rst_d     = m_rst_q;
    m_wr_d      = m_wr_q;
    m_addr_d    = m_addr_q;
    m_din_d     = m_din_q;
    strobe_d    = strobe_q;
    unique case (state_q)
      StIdle: begin
        m_rst_d = 1'b1;
        if (|req) begin
          gnt_d    = sel_gnt;
          m_wr_d   = sel_wr;
          m_addr_d = sel_addr;
          m_din_d  = sel_din;
          rsp_id_d = win;
          ptr_d    = (win == IdW'(N_REQ - 1)) ? '0 : win + IdW'(1);
          busy_d   = 1'b1;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        m_rst_d = 1'b0;
        cnt_d   = '0;
        state_d = StAddrPh;
      end
      StAddrPh: begin
        // Master needs ACK1_DLY cycles out of reset before the first ack window.
        if (cnt_q == CntLast) begin
          strobe_d = 1'b1;
          state_d  = StDataPh;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDataPh: begin
        if (m_done) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_wr_q ? 8'h00 : m_temprd;
          rsp_err_d   = 1'b0;
          m_rst_d     = 1'b1;
          strobe_d    = 1'b0;
          state_d     = StRecover;
        end
      end
      StRecover: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef I2C_ARB_TIMEOUT_EN
    wd_d = wd_q;
    if (state_q == StLaunch) wd_d = '0;
    if (state_q == StAddrPh || state_q == StDataPh) begin
      wd_d = wd_q + 1'b1;
      // A completion landing on the expiry cycle takes precedence.
      if (wd_q == WdLast && !(state_q == StDataPh && m_done)) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 8'h00;
        m_rst_d     = 1'b1;
        strobe_d    = 1'b0;
        state_d     = StRecover;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      m_rst_q     <= 1'b1;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_din_q     <= '0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      m_rst_q     <= m_rst_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_din_q     <= m_din_d;
      strobe_q    <= strobe_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  assign gnt              = gnt_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_id           = rsp_id_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign busy             = busy_q;
  assign m_rst            = m_rst_q;
  assign m_wr             = m_wr_q;
  assign m_addr           = m_addr_q;
  assign m_din            = m_din_q;
  assign m_update         = strobe_q;
  assign m_send_ack_start = strobe_q;
  assign m_send_ack_end   = strobe_q;

endmodule
